// File: rtl/io_bus_bridge.sv
// Memory-mapped I/O bridge: decodes a channel index from the CPU address and runs a
// level req/done handshake with one of N_CH peripherals. It adds a timeout and a sticky error flag.
module io_bus_bridge #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int N_CH     = 4,
  parameter int CH_LSB   = 8,
  parameter int CH_BITS  = 4,
  parameter int TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  input  logic               cpu_we,
  input  logic               cpu_re,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_ack,
  output logic [N_CH-1:0]    per_req,
  output logic               per_we,
  output logic [AW-1:0]      per_addr,
  output logic [DW-1:0]      per_wdata,
  input  logic [N_CH*DW-1:0] per_rdata,
  input  logic [N_CH-1:0]    per_done,
  output logic               err_flag,
  input  logic               err_clr
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK, HOLD} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [CH_BITS-1:0] idx;
  logic              idx_ok;
  logic              req_any;
  logic              done_hit;
  logic              timed_out;
  logic              set_err;
  logic              ack_nx;
  logic [N_CH-1:0]   sel;
  logic [DW-1:0]     done_data;

  assign idx       = cpu_addr[CH_LSB +: CH_BITS];
  assign idx_ok    = (int'(idx) < N_CH);
  assign req_any   = cpu_we | cpu_re;
  // per_req is one-hot on the selected channel, so masking ignores other channels' done bits
  assign done_hit  = |(per_req & per_done);
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    sel       = '0;
    done_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel[i] = (int'(idx) == i);
      if (per_req[i]) done_data = per_rdata[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_any) state_nx = idx_ok ? BUSY : ACK;
      BUSY: if (done_hit || timed_out) state_nx = ACK;
      ACK:  state_nx = HOLD;
      HOLD: if (!req_any) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    set_err = 1'b0;
    ack_nx  = (state_nx == ACK);
    if (state == IDLE && req_any && !idx_ok) set_err = 1'b1;
    if (state == BUSY && !done_hit && timed_out) set_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_req   <= '0;
      per_we    <= 1'b0;
      per_addr  <= '0;
      per_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      err_flag  <= 1'b0;
      cnt       <= '0;
    end else begin
      cpu_ack  <= ack_nx;
      err_flag <= set_err ? 1'b1 : (err_clr ? 1'b0 : err_flag);
      case (state)
        IDLE: if (req_any) begin
          per_addr  <= cpu_addr;
          per_wdata <= cpu_wdata;
          per_we    <= cpu_we;
          cnt       <= '0;
          if (idx_ok) per_req   <= sel;
          else        cpu_rdata <= ERR_DATA;
        end
        BUSY: begin
          if (done_hit) begin
            per_req <= '0;
            if (!per_we) cpu_rdata <= done_data;
          end else if (timed_out) begin
            per_req   <= '0;
            cpu_rdata <= ERR_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Bench for io_bus_bridge: a transaction-timing model predicts per-cycle outputs,
// and directed accesses carry hand-computed latency and data expectations.
module tb_io_bus_bridge;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, per_addr, per_wdata;
  logic        cpu_we, cpu_re, cpu_ack, per_we, err_flag, err_clr;
  logic [3:0]  per_req, per_done;
  logic [63:0] per_rdata;

  io_bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_rdata(per_rdata), .per_done(per_done), .err_flag(err_flag), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk = 0, n_fail = 0, n_acks = 0, obs_ack = 0;
  int          acc_t0, win_s, win_e, exp_ack;
  logic [3:0]  win_val, req_c1;
  logic [15:0] acc_addr, acc_wdata, new_rdata, m_addr, m_wdata, m_rdata, obs_rdata;
  logic        acc_we, new_err, m_we, m_err, clr_q, obs_err;
  bit          chk_on = 0;

  function automatic logic [15:0] peri_val(input int ch);
    case (ch)
      0: return 16'h0F0F;
      1: return 16'hA1A1;
      2: return 16'h1234;
      default: return 16'hC3C3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the transaction model
  always @(negedge clk) begin
    logic [3:0] exp_req;
    if (rst) begin
      chk("rst_req", per_req, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_err", err_flag, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_addr", per_addr, 0);
      chk("rst_wdata", per_wdata, 0);
      chk("rst_we", per_we, 0);
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_we = 0; m_err = 0; clr_q = 0;
      win_s = -10; win_e = -20; win_val = 0; exp_ack = -1; acc_t0 = -100;
    end else if (chk_on) begin
      if (cyc == acc_t0 + 1) begin
        m_addr = acc_addr; m_wdata = acc_wdata; m_we = acc_we;
      end
      if (cyc == exp_ack) m_rdata = new_rdata;
      m_err   = (cyc == exp_ack && new_err) ? 1'b1 : (clr_q ? 1'b0 : m_err);
      exp_req = (cyc >= win_s && cyc <= win_e) ? win_val : 4'b0;
      chk("cyc_req", per_req, exp_req);
      chk("cyc_ack", cpu_ack, (cyc == exp_ack));
      chk("cyc_rdata", cpu_rdata, m_rdata);
      chk("cyc_err", err_flag, m_err);
      chk("cyc_addr", per_addr, m_addr);
      chk("cyc_wdata", per_wdata, m_wdata);
      if (exp_req != 0) chk("cyc_we", per_we, m_we);
      clr_q = err_clr;
      if (cpu_ack) begin
        n_acks++; obs_ack = cyc; obs_rdata = cpu_rdata; obs_err = err_flag;
      end
    end
  end

  // d: cycle (relative to request) at which per_done[ch] rises, 0 = never; oc: unrelated done
  task automatic access(input logic we, input logic re, input logic [15:0] addr,
                        input logic [15:0] wdata, input int d, input int oc, input int hold);
    int ch, rel;
    @(posedge clk); #1;
    ch = int'(addr[11:8]);
    acc_t0 = cyc; acc_addr = addr; acc_wdata = wdata; acc_we = we;
    if (ch >= 4) begin
      win_s = -10; win_e = -20; win_val = 0; rel = 1;
      new_rdata = 16'hDEAD; new_err = 1;
    end else begin
      win_val = 4'b0001 << ch;
      win_s   = cyc + 1;
      if (d >= 1 && d <= TO) begin
        rel = d + 1; new_err = 0;
        new_rdata = we ? m_rdata : peri_val(ch);
      end else begin
        rel = TO + 1; new_err = 1; new_rdata = 16'hDEAD;
      end
      win_e = cyc + rel - 1;
    end
    exp_ack = cyc + rel;
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wdata;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (n == 1) req_c1 = per_req;
      if (oc >= 0 && n == 1) per_done[oc] = 1'b1;
      if (ch < 4 && n == d) per_done[ch] = 1'b1;
      if (cyc >= exp_ack) break;
    end
    per_done = '0;
    repeat (hold) begin @(posedge clk); #1; end
    cpu_re = 0; cpu_we = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1; cpu_addr = 0; cpu_wdata = 0; cpu_we = 0; cpu_re = 0;
    per_done = 0; err_clr = 0;
    per_rdata = {peri_val(3), peri_val(2), peri_val(1), peri_val(0)};
    repeat (3) @(posedge clk);
    #1; rst = 0; chk_on = 1;

    access(0, 1, 16'h0210, 16'h0000, 4, -1, 0);
    chk("t1_req_c1", req_c1, 4'b0100);
    chk("t1_lat", obs_ack - acc_t0, 5);
    chk("t1_rdata", obs_rdata, 16'h1234);
    chk("t1_err", obs_err, 0);

    access(1, 0, 16'h0005, 16'hBEEF, 1, -1, 0);
    chk("t2_lat", obs_ack - acc_t0, 2);
    chk("t2_wdata", per_wdata, 16'hBEEF);
    chk("t2_we", per_we, 1);
    chk("t2_rdata", obs_rdata, 16'h1234);

    access(0, 1, 16'h0900, 16'h0000, 0, -1, 0);
    chk("t3_lat", obs_ack - acc_t0, 1);
    chk("t3_rdata", obs_rdata, 16'hDEAD);
    chk("t3_err", err_flag, 1);
    err_clr = 1; @(posedge clk); #1; err_clr = 0;
    chk("t3_clr", err_flag, 0);

    err_clr = 1;
    access(0, 1, 16'h0F00, 16'h0000, 0, -1, 0);
    chk("prio_err_at_ack", obs_err, 1);
    chk("prio_cleared_after", err_flag, 0);
    err_clr = 0;

    access(0, 1, 16'h0100, 16'h0000, 0, -1, 0);
    chk("t4_req_c1", req_c1, 4'b0010);
    chk("t4_lat", obs_ack - acc_t0, 9);
    chk("t4_rdata", obs_rdata, 16'hDEAD);
    chk("t4_err", err_flag, 1);

    access(0, 1, 16'h0140, 16'h0000, 2, 3, 0);
    chk("other_lat", obs_ack - acc_t0, 3);
    chk("other_rdata", obs_rdata, 16'hA1A1);

    access(0, 1, 16'h03FF, 16'h0000, 8, -1, 0);
    chk("edge_done_lat", obs_ack - acc_t0, 9);
    chk("edge_done_rdata", obs_rdata, 16'hC3C3);

    access(0, 1, 16'h0200, 16'h0000, 9, -1, 0);
    chk("edge_to_lat", obs_ack - acc_t0, 9);
    chk("edge_to_rdata", obs_rdata, 16'hDEAD);

    k = n_acks;
    access(1, 1, 16'h0277, 16'h5A5A, 2, -1, 10);
    chk("t5_one_ack", n_acks - k, 1);
    chk("t5_lat", obs_ack - acc_t0, 3);
    chk("t5_we", per_we, 1);
    chk("t5_rdata", obs_rdata, 16'hDEAD);

    @(posedge clk); #1;
    acc_t0 = cyc; acc_addr = 16'h0300; acc_wdata = 16'h0000; acc_we = 0;
    win_val = 4'b1000; win_s = cyc + 1; win_e = cyc + TO; exp_ack = cyc + TO + 1;
    new_rdata = 16'hDEAD; new_err = 1;
    cpu_re = 1; cpu_addr = 16'h0300; cpu_wdata = 16'h0000;
    repeat (3) begin @(posedge clk); #1; end
    chk("t6_busy", per_req, 4'b1000);
    k = n_acks;
    rst = 1; cpu_re = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (15) begin @(posedge clk); #1; end
    chk("t6_no_ack", n_acks - k, 0);
    chk("t6_err", err_flag, 0);
    chk("t6_req", per_req, 0);

    access(0, 1, 16'h0210, 16'h0000, 1, -1, 0);
    chk("t6_idle_lat", obs_ack - acc_t0, 2);
    chk("t6_idle_rdata", obs_rdata, 16'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
